// File: rtl/phrase_ram_pkg.sv
// phrase_ram_pkg: shared state enum and default geometry for phrase_ram
package phrase_ram_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 13;
  typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/phrase_ram_clear_ctrl.sv
// phrase_ram_clear_ctrl: IDLE/CLEAR sweep FSM and clear address counter
module phrase_ram_clear_ctrl
  import phrase_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && clear_req) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      // the counter parks on the last address instead of wrapping
      state_d = (cnt_q == LAST) ? IDLE : CLEAR;
      cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end
  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;
endmodule

// File: rtl/phrase_ram.sv
// phrase_ram: single-port-write/read RAM with clear sweep on reset or request.
// Define PHRASE_RAM_BYPASS_EN for write-first forwarding on same-address access.
module phrase_ram
  import phrase_ram_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_ram,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address_wr,
  input  logic [ADDR_W-1:0] address_rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              read_valid,
  output logic              busy
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              clr_we, mem_we, rd_en, valid_q, valid_d;
  logic [ADDR_W-1:0] clr_addr, mem_wa;
  logic [DATA_W-1:0] mem_wd, rd_word, data_q, data_d;
  phrase_ram_clear_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  always_comb begin
    mem_we  = clr_we | (~busy & enable_ram & write_enable);
    mem_wa  = busy ? clr_addr : address_wr;
    mem_wd  = busy ? CLEAR_VALUE : data_in;
    rd_en   = ~busy & enable_ram;
`ifdef PHRASE_RAM_BYPASS_EN
    rd_word = (write_enable && address_wr == address_rd) ? data_in : mem[address_rd];
`else
    rd_word = mem[address_rd];
`endif
    data_d  = rd_en ? rd_word : data_q;
    valid_d = rd_en;
  end
  always_ff @(posedge clock)
    if (mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign data_out   = data_q;
  assign read_valid = valid_q;
endmodule
